// File: rtl/muldiv_hilo_unit_if.sv
// muldiv_hilo_unit_if
// Decoder-side bundle for the HI/LO multiply unit.
//   master : the decoder/pipeline; drives the control word, operands, kill and
//            MTHI/MTLO writes, and observes busy/done/hi/lo.
//   slave  : the multiply unit itself.
// Signals:
//   start, op_signed, op_acc, src_a[31:0], src_b[31:0]  multiply launch
//   kill                                                exception flush
//   mthi_we, mtlo_we, mt_data[31:0]                     MTHI/MTLO writes
//   busy, done, hi[31:0], lo[31:0]                      status and HI/LO
interface muldiv_hilo_unit_if;
  logic        start;
  logic        op_signed;
  logic        op_acc;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        kill;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op_signed, op_acc, src_a, src_b, kill,
           mthi_we, mtlo_we, mt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_signed, op_acc, src_a, src_b, kill,
           mthi_we, mtlo_we, mt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
// Iterative MULT/MULTU/MADD/MADDU engine that owns the architectural HI/LO
// registers and also services MTHI/MTLO. Multiplies operand magnitudes with
// STEP_BITS multiplier bits per cycle, then applies the sign and the optional
// accumulate in a single FINISH cycle.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      muldiv_hilo_unit_if.slave (control word, operands, kill,
//            MTHI/MTLO, busy, done, hi, lo)
// Parameters:
//   STEP_BITS  multiplier bits retired per cycle (1, 2 or 4); RUN lasts
//              32/STEP_BITS cycles
//
// state  | meaning
// IDLE   | waiting; accepts start or MTHI/MTLO
// RUN    | retiring STEP_BITS multiplier bits per cycle into the partial product
// FINISH | sign-correct, optionally accumulate, load HI/LO, pulse done
module muldiv_hilo_unit #(
  parameter int STEP_BITS = 2
) (
  input logic               clk,
  input logic               reset_n,
  muldiv_hilo_unit_if.slave bus
);

  localparam int N  = 32 / STEP_BITS;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            mcand_q, mplier_q;
  logic [63:0]            prod_q;
  logic [CW-1:0]          cnt_q;
  logic                   sign_q, acc_q, done_q;
  logic [31:0]            hi_q, lo_q;

  logic                   launch, mt_ok, fin_load, busy_c;
  logic                   last_step;
  logic [31:0]            a_mag, b_mag;
  logic [STEP_BITS-1:0]   digit;
  logic [5:0]             shamt;
  logic [63:0]            addend, prod_signed, result;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start && !bus.kill) state_d = S_RUN;
      S_RUN:    if (bus.kill)               state_d = S_IDLE;
                else if (last_step)         state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    launch   = 1'b0;
    mt_ok    = 1'b0;
    fin_load = 1'b0;
    busy_c   = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        launch = bus.start && !bus.kill;
        // start takes priority over MTHI/MTLO; kill suppresses both
        mt_ok  = !bus.start && !bus.kill;
      end
      S_FINISH: fin_load = !bus.kill;
      default: ;
    endcase
  end

  // Magnitudes: -2^31 negates to itself, which read as unsigned is 2^31.
  assign a_mag = (bus.op_signed && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
  assign b_mag = (bus.op_signed && bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;

  assign last_step = (cnt_q == CW'(N - 1));
  assign digit     = mplier_q[STEP_BITS-1:0];
  assign shamt     = 6'(cnt_q) << $clog2(STEP_BITS);
  assign addend    = ({32'd0, mcand_q} * {{(64-STEP_BITS){1'b0}}, digit}) << shamt;

  assign prod_signed = sign_q ? (~prod_q + 64'd1) : prod_q;
  assign result      = acc_q ? ({hi_q, lo_q} + prod_signed) : prod_signed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      acc_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= fin_load;

      if (launch) begin
        mcand_q  <= a_mag;
        mplier_q <= b_mag;
        sign_q   <= bus.op_signed & (bus.src_a[31] ^ bus.src_b[31]);
        acc_q    <= bus.op_acc;
        prod_q   <= '0;
        cnt_q    <= '0;
      end else if (state_q == S_RUN) begin
        prod_q   <= prod_q + addend;
        mplier_q <= mplier_q >> STEP_BITS;
        cnt_q    <= cnt_q + CW'(1);
      end

      if (fin_load) begin
        hi_q <= result[63:32];
        lo_q <= result[31:0];
      end else if (mt_ok) begin
        if (bus.mthi_we) hi_q <= bus.mt_data;
        if (bus.mtlo_we) lo_q <= bus.mt_data;
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;

  localparam int STEP     = 2;
  localparam int N        = 32 / STEP;
  localparam int BUSY_LEN = N + 1;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  muldiv_hilo_unit_if bus();

  muldiv_hilo_unit #(.STEP_BITS(STEP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic        acc;
    logic        pre;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start     = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_acc    = 1'b0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.kill      = 1'b0;
    bus.mthi_we   = 1'b0;
    bus.mtlo_we   = 1'b0;
    bus.mt_data   = '0;
  endtask

  task automatic mt_write(input logic hwe, input logic lwe, input logic [31:0] d);
    bus.mthi_we = hwe;
    bus.mtlo_we = lwe;
    bus.mt_data = d;
    tick();
    bus.mthi_we = 1'b0;
    bus.mtlo_we = 1'b0;
  endtask

  task automatic launch(input logic sgn, input logic acc, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op_signed = sgn;
    bus.op_acc    = acc;
    bus.src_a     = a;
    bus.src_b     = b;
    tick();
    bus.start     = 1'b0;
  endtask

  // Waits (bounded) for busy to drop, counting busy cycles and done pulses,
  // then one extra cycle to make sure done is only a single pulse.
  task automatic wait_idle(output int busy_cyc, output int done_cnt);
    busy_cyc = 0;
    done_cnt = 0;
    while (bus.busy && busy_cyc < 100) begin
      busy_cyc++;
      tick();
      if (bus.done) done_cnt++;
    end
    tick();
    if (bus.done) done_cnt++;
  endtask

  task automatic run_op(input logic sgn, input logic acc, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output int done_cnt);
    launch(sgn, acc, a, b);
    wait_idle(busy_cyc, done_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, dc;
    logic [31:0] keep_hi, keep_lo;

    //         sgn  acc  pre  pre_hi        pre_lo        a             b             exp_hi        exp_lo
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0,        32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h0,        32'h0000000A, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h00000005, 32'h00000006, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};

    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_hi",   bus.hi,   0);
    chk("reset_lo",   bus.lo,   0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].pre) begin
        mt_write(1'b1, 1'b0, vecs[i].pre_hi);
        mt_write(1'b0, 1'b1, vecs[i].pre_lo);
      end
      run_op(vecs[i].sgn, vecs[i].acc, vecs[i].a, vecs[i].b, bc, dc);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(BUSY_LEN));
      chk($sformatf("vec%0d_done_pulses", i), 64'(dc), 64'd1);
      chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
    end

    // Kill in the 5th RUN cycle
    keep_hi = 32'h11111111;
    keep_lo = 32'h22222222;
    mt_write(1'b1, 1'b0, keep_hi);
    mt_write(1'b0, 1'b1, keep_lo);
    launch(1'b0, 1'b0, 32'd3, 32'd5);
    repeat (4) tick();
    chk("kill_run_busy_before", bus.busy, 1);
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    chk("kill_run_busy", bus.busy, 0);
    chk("kill_run_done", bus.done, 0);
    dc = 0;
    bc = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done) dc++;
      if (bus.busy) bc++;
    end
    chk("kill_run_no_done", 64'(dc), 0);
    chk("kill_run_no_busy", 64'(bc), 0);
    chk("kill_run_hi", bus.hi, keep_hi);
    chk("kill_run_lo", bus.lo, keep_lo);

    // Kill in FINISH
    launch(1'b0, 1'b0, 32'd3, 32'd5);
    repeat (N) tick();
    chk("kill_fin_busy_before", bus.busy, 1);
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    chk("kill_fin_busy", bus.busy, 0);
    chk("kill_fin_done", bus.done, 0);
    dc = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done) dc++;
    end
    chk("kill_fin_no_done", 64'(dc), 0);
    chk("kill_fin_hi", bus.hi, keep_hi);
    chk("kill_fin_lo", bus.lo, keep_lo);

    // start and MTHI while busy are ignored
    launch(1'b0, 1'b0, 32'd3, 32'd5);
    repeat (2) tick();
    bus.start   = 1'b1;
    bus.src_a   = 32'd100;
    bus.src_b   = 32'd100;
    bus.mthi_we = 1'b1;
    bus.mt_data = 32'hDEADBEEF;
    tick();
    clear_inputs();
    wait_idle(bc, dc);
    chk("busy_ign_busy_cycles", 64'(bc), 64'(BUSY_LEN - 3));
    chk("busy_ign_done", 64'(dc), 1);
    chk("busy_ign_hi", bus.hi, 0);
    chk("busy_ign_lo", bus.lo, 15);
    chk("busy_ign_no_relaunch", bus.busy, 0);

    // kill in IDLE drops start and MT writes
    bus.kill    = 1'b1;
    bus.start   = 1'b1;
    bus.src_a   = 32'd9;
    bus.src_b   = 32'd9;
    bus.mthi_we = 1'b1;
    bus.mtlo_we = 1'b1;
    bus.mt_data = 32'h00005A5A;
    tick();
    clear_inputs();
    chk("idle_kill_busy", bus.busy, 0);
    chk("idle_kill_hi", bus.hi, 0);
    chk("idle_kill_lo", bus.lo, 15);

    // MTHI and MTLO together
    mt_write(1'b1, 1'b1, 32'hA5A5A5A5);
    chk("mt_both_hi", bus.hi, 32'hA5A5A5A5);
    chk("mt_both_lo", bus.lo, 32'hA5A5A5A5);
    chk("mt_busy", bus.busy, 0);
    chk("mt_done", bus.done, 0);

    // start wins over MTHI in the same cycle: MADDU 0*0 leaves HI:LO as is
    bus.mthi_we = 1'b1;
    bus.mt_data = 32'h12345678;
    launch(1'b0, 1'b1, 32'd0, 32'd0);
    bus.mthi_we = 1'b0;
    chk("start_prio_busy", bus.busy, 1);
    wait_idle(bc, dc);
    chk("start_prio_hi", bus.hi, 32'hA5A5A5A5);
    chk("start_prio_lo", bus.lo, 32'hA5A5A5A5);

    // Asynchronous reset mid-RUN
    launch(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.done, 0);
    chk("async_rst_hi", bus.hi, 0);
    chk("async_rst_lo", bus.lo, 0);
    #1;
    reset_n = 1'b1;
    tick();
    run_op(1'b0, 1'b0, 32'd7, 32'd6, bc, dc);
    chk("post_rst_busy_cycles", 64'(bc), 64'(BUSY_LEN));
    chk("post_rst_done", 64'(dc), 1);
    chk("post_rst_hi", bus.hi, 0);
    chk("post_rst_lo", bus.lo, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
